rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one single-port template ROM among NUM_REQ requesters (template matcher, HDMI overlay, debug readout).
- The ROM has 11-bit address, 8-bit data and 1-cycle read latency with no output register.
- Each requester asks for a burst of sequential reads from a start address.
- The block grants round-robin, drives the ROM address bus, and returns tagged data plus a done pulse.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 11: ROM address width.
- DATA_WIDTH, 8: ROM data width.
- LEN_WIDTH, 12: burst length width; allows 0..2^ADDR_WIDTH reads.
- ID_WIDTH, 3: requester id width; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until its gnt.
- req_addr  in  NUM_REQ*ADDR_WIDTH  start addresses, flattened, requester 0 in the LSBs.
- req_len  in  NUM_REQ*LEN_WIDTH  burst lengths, flattened.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse when a burst is accepted.
- rd_vld  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_WIDTH  ROM data, passed through from rom_rd_data.
- rd_id  out  ID_WIDTH  requester owning rd_data.
- done  out  NUM_REQ  one-hot, 1-cycle pulse coincident with the last rd_vld of a burst.
- busy  out  1  high from gnt until the cycle after done.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_rst  out  1  ROM reset; equals ~rst_n (the ROM reset is active-high).
- rom_rd_data  in  DATA_WIDTH  ROM read data.

Behaviour:
- Reset values: all outputs 0 except rom_rst, which is 1 while reset is asserted; FSM in IDLE; round-robin pointer 0; counters 0.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - If any req is high, choose the first set bit starting at (last_granted+1) mod NUM_REQ; after reset the search starts at index 0.
  - On that edge: gnt[i]=1 for one cycle, latch id/addr/len, rom_addr<=req_addr[i], last_granted<=i.
  - If len != 0, go to BURST; else pulse done[i] the next cycle with no rd_vld and return to IDLE.
- BURST:
  - Each cycle the current rom_addr counts as one issued read.
  - rom_addr increments by 1 modulo 2^ADDR_WIDTH, so 0x7FF wraps to 0x000. The remaining count decrements.
  - When the final read is issued, go to DRAIN; rom_addr holds its last value.
- Read latency READ_LAT = 1:
  - A read issued in cycle c gives rd_vld=1 in cycle c+1, with rd_id = latched id.
  - rd_vld is produced by a READ_LAT-deep shift register of issue flags.
- DRAIN:
  - Wait until the issue pipeline is empty. done[id] pulses together with the final rd_vld.
  - The FSM returns to IDLE in the cycle after done, so the next gnt is at the earliest 2 cycles after done.
- Throughput: one byte per cycle within a burst, with no bubbles.
- Requesters:
  - req is sampled only in IDLE.
  - Deasserting req before its gnt withdraws the request.
  - req_addr and req_len are captured only at gnt and may change afterwards.
  - A requester may re-request immediately after its done. Round-robin guarantees no starvation.
- Simultaneous requests: exactly one gnt bit is set per acceptance.
- Reset mid-burst: everything clears asynchronously; no done is issued for the aborted burst.
- Lengths above 2^ADDR_WIDTH are saturated to 2^ADDR_WIDTH.

Optional Feature:
- Macro ROM_OUT_REG_EN.
- When defined, the ROM is built with OUTPUT_REG=1. READ_LAT becomes 2 and rd_data is taken one cycle later; the DRAIN wait extends accordingly.
- When undefined, READ_LAT=1 as specified above.
- Grant and address timing are identical in both builds.

Decomposition:
- Package rom_arb_pkg holds:
  - FSM state enum (IDLE, BURST, DRAIN).
  - READ_LAT constant, selected by ROM_OUT_REG_EN.
  - Default widths.
- Sub-module rr_arbiter: combinational round-robin picker with inputs req and last_granted, outputs one-hot grant and index. It is reusable elsewhere in the ISP.

Test Plan:
- Single burst:
  - Stimulus: req[0]=1, addr=0x010, len=4, ROM content mem[a]=a[7:0].
  - Expect: gnt[0] pulse; rom_addr 0x010..0x013 on consecutive cycles; rd_vld for 4 cycles with data 0x10,0x11,0x12,0x13 and rd_id=0; done[0] on the 4th rd_vld.
- Wrap-around:
  - Stimulus: addr=0x7FE, len=4.
  - Expect: rom_addr 0x7FE, 0x7FF, 0x000, 0x001; data 0xFE, 0xFF, 0x00, 0x01.
- Contention:
  - Stimulus: req[0] and req[1] both held continuously, len=2 each.
  - Expect grants in the order 0,1,0,1; no rd_vld overlap between bursts; every done matches its gnt id.
- Zero length:
  - Stimulus: req[1] with len=0.
  - Expect: gnt[1], then done[1] the next cycle, with no rd_vld.
- Reset mid-burst:
  - Stimulus: len=100, assert rst_n=0 after 10 data beats.
  - Expect: outputs go to 0 immediately and no done pulse.
  - Then: a new req[1] after release is granted first.
- ROM_OUT_REG_EN build:
  - Stimulus: rerun the single-burst case.
  - Expect: first rd_vld 2 cycles after the first rom_addr; data unchanged; done aligned with the 4th rd_vld.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared FSM type, read latency and default widths; ROM_OUT_REG_EN selects READ_LAT
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

`ifdef ROM_OUT_REG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 12;
    localparam int DEF_ID_WIDTH   = 3;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// rtl/rom_read_arbiter_if.sv - requester-side bus of the ROM read arbiter
interface rom_read_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12,
    parameter int ID_WIDTH   = 3
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            gnt;
    logic                          rd_vld;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic [ID_WIDTH-1:0]           rd_id;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;

    // requester side
    modport master (
        output req, req_addr, req_len,
        input  gnt, rd_vld, rd_data, rd_id, done, busy
    );

    // arbiter side
    modport slave (
        input  req, req_addr, req_len,
        output gnt, rd_vld, rd_data, rd_id, done, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches from last_granted+1 (or 0 when fresh)
module rr_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 3
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_granted,
    input  logic                fresh,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] index,
    output logic                valid
);

    // first set request in rotating priority order
    always_comb begin
        int k;
        grant = '0;
        index = '0;
        valid = 1'b0;
        k     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = fresh ? off : (int'(last_granted) + 1 + off) % NUM_REQ;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                index    = ID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin burst reader sharing one ROM; ROM_OUT_REG_EN adds a ROM output register stage
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_read_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rst,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;

    arb_state_t            state, state_nxt;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [ID_WIDTH-1:0]   arb_index;
    logic                  arb_valid;
    logic [ID_WIDTH-1:0]   last_granted;
    logic                  granted_once;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  len_sel;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic                  zlen;
    logic                  zero_done;
    logic [READ_LAT-1:0]   iss_sr;
    logic [READ_LAT-1:0]   last_sr;
    logic                  issue;
    logic                  final_issue;
    logic                  done_now;
    logic                  rd_vld;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req          (bus.req),
        .last_granted (last_granted),
        .fresh        (~granted_once),
        .grant        (arb_grant),
        .index        (arb_index),
        .valid        (arb_valid)
    );

    assign addr_sel = bus.req_addr[int'(arb_index)*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_sel  = bus.req_len[int'(arb_index)*LEN_WIDTH +: LEN_WIDTH];
    assign len_sat  = (len_sel > MAX_LEN) ? MAX_LEN : len_sel;

    // done fires with the last data beat, or one cycle after a zero-length grant
    assign done_now = last_sr[READ_LAT-1] | zero_done;
    assign rd_vld   = iss_sr[READ_LAT-1];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and per-cycle read issue
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        final_issue = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) state_nxt = (len_sel != '0) ? BURST : DRAIN;
            end
            BURST: begin
                issue = 1'b1;
                if (remaining == LEN_WIDTH'(1)) begin
                    final_issue = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (done_now) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant capture, address counter and issue pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            last_granted <= '0;
            granted_once <= 1'b0;
            id_q         <= '0;
            remaining    <= '0;
            rom_addr_q   <= '0;
            zlen         <= 1'b0;
            zero_done    <= 1'b0;
            iss_sr       <= '0;
            last_sr      <= '0;
        end else begin
            gnt_q      <= '0;
            zero_done  <= (state == DRAIN) && zlen && !zero_done;
            iss_sr[0]  <= issue;
            last_sr[0] <= final_issue;
            for (int k = 1; k < READ_LAT; k++) begin
                iss_sr[k]  <= iss_sr[k-1];
                last_sr[k] <= last_sr[k-1];
            end
            if (state == IDLE && arb_valid) begin
                gnt_q        <= arb_grant;
                last_granted <= arb_index;
                granted_once <= 1'b1;
                id_q         <= arb_index;
                rom_addr_q   <= addr_sel;
                remaining    <= len_sat;
                zlen         <= (len_sel == '0);
            end else if (state == BURST && remaining != LEN_WIDTH'(1)) begin
                rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
                remaining  <= remaining - LEN_WIDTH'(1);
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_rst     = ~rst_n;
    assign bus.gnt     = gnt_q;
    assign bus.rd_vld  = rd_vld;
    assign bus.rd_data = rd_vld ? rom_rd_data : '0;
    assign bus.rd_id   = rd_vld ? id_q : '0;
    assign bus.done    = done_now ? (NUM_REQ'(1) << id_q) : '0;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - scoreboard bench for rom_read_arbiter
module tb_rom_read_arbiter;

`ifdef ROM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         last;
        bit         zl;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [10:0] rom_addr;
    logic        rom_rst;
    logic [7:0]  rom_rd_data;
    logic [7:0]  rom_q1;
    logic [7:0]  rom_q2;

    int    vectors;
    int    miscompares;
    beat_t exp_q[$];
    beat_t mon_e;

    rom_read_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(11), .DATA_WIDTH(8), .LEN_WIDTH(12), .ID_WIDTH(3)) bus ();

    rom_read_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rom_addr    (rom_addr),
        .rom_rst     (rom_rst),
        .rom_rd_data (rom_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: mem[a] = a[7:0]
    always @(posedge clk or posedge rom_rst) begin
        if (rom_rst) begin
            rom_q1 <= '0;
            rom_q2 <= '0;
        end else begin
            rom_q1 <= rom_addr[7:0];
            rom_q2 <= rom_q1;
        end
    end
`ifdef ROM_OUT_REG_EN
    assign rom_rd_data = rom_q2;
`else
    assign rom_rd_data = rom_q1;
`endif

    // scoreboard: every data beat and every done is matched against the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_vld) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_beat: data %h id %0d, required no beat", bus.rd_data, bus.rd_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.rd_data !== mon_e.data || bus.rd_id !== 3'(mon_e.id)) begin
                        miscompares++;
                        $display("FAIL sb_beat: data %h id %0d, required data %h id %0d", bus.rd_data, bus.rd_id, mon_e.data, mon_e.id);
                    end
                    vectors++;
                    if (bus.done !== (mon_e.last ? 2'(1 << mon_e.id) : 2'b00)) begin
                        miscompares++;
                        $display("FAIL sb_done_on_beat: done %b, required %b", bus.done, mon_e.last ? 2'(1 << mon_e.id) : 2'b00);
                    end
                end
            end else if (bus.done !== 2'b00) begin
                vectors++;
                if (exp_q.size() == 0 || !exp_q[0].zl) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_done: done %b without data, required none", bus.done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.done !== 2'(1 << mon_e.id)) begin
                        miscompares++;
                        $display("FAIL sb_zero_done: done %b, required %b", bus.done, 2'(1 << mon_e.id));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_len  = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.gnt !== 2'b00 || bus.rd_vld !== 1'b0 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt %b vld %b done %b busy %b, required all 0", bus.gnt, bus.rd_vld, bus.done, bus.busy);
        end
        vectors++;
        if (rom_addr !== 11'h000 || rom_rst !== 1'b1 || bus.rd_data !== 8'h00 || bus.rd_id !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_rom: addr %h rst %b data %h id %0d, required 000 1 00 0", rom_addr, rom_rst, bus.rd_data, bus.rd_id);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (rom_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_rom_rst: %b, required 0", rom_rst);
        end
    endtask

    task automatic test_burst(input string tag, input int id, input logic [10:0] addr, input int len);
        int         cyc, g_cyc, first_vld, beats, done_cyc;
        bit         got_gnt;
        logic [10:0] ea;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            ea = addr + 11'(i);
            exp_q.push_back('{id: id, data: ea[7:0], last: (i == len - 1), zl: 1'b0});
        end
        bus.req_addr[id*11 +: 11] = addr;
        bus.req_len[id*12 +: 12]  = 12'(len);
        bus.req[id]               = 1'b1;
        cyc = 0; g_cyc = 0; first_vld = -1; beats = 0; done_cyc = -1; got_gnt = 1'b0;
        while (cyc < 300 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt !== 2'b00) begin
                vectors++;
                if (bus.gnt !== 2'(1 << id) || got_gnt) begin
                    miscompares++;
                    $display("FAIL %s_gnt: %b, required single %b", tag, bus.gnt, 2'(1 << id));
                end
                got_gnt     = 1'b1;
                g_cyc       = cyc;
                bus.req[id] = 1'b0;
            end
            if (got_gnt && cyc - g_cyc < len) begin
                ea = addr + 11'(cyc - g_cyc);
                vectors++;
                if (rom_addr !== ea) begin
                    miscompares++;
                    $display("FAIL %s_rom_addr: %h, required %h", tag, rom_addr, ea);
                end
            end
            if (bus.rd_vld === 1'b1) begin
                if (first_vld < 0) first_vld = cyc;
                beats++;
            end
            if (bus.done !== 2'b00) done_cyc = cyc;
        end
        vectors++;
        if (done_cyc < 0 || !got_gnt) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within 300 cycles, required done", tag);
            bus.req[id] = 1'b0;
        end else begin
            if (first_vld - g_cyc != LAT || beats != len || done_cyc != first_vld + len - 1) begin
                miscompares++;
                $display("FAIL %s_timing: latency %0d beats %0d done_at %0d, required %0d %0d %0d",
                         tag, first_vld - g_cyc, beats, done_cyc - first_vld, LAT, len, len - 1);
            end
            @(negedge clk);
            vectors++;
            if (bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_busy_after_done: %b, required 0", tag, bus.busy);
            end
        end
    endtask

    task automatic test_zero_length();
        int cyc, g_cyc, done_cyc, vld_cnt;
        @(negedge clk);
        exp_q.push_back('{id: 1, data: 8'h00, last: 1'b1, zl: 1'b1});
        bus.req_addr[11 +: 11] = 11'h055;
        bus.req_len[12 +: 12]  = 12'd0;
        bus.req[1]             = 1'b1;
        cyc = 0; g_cyc = -100; done_cyc = -1; vld_cnt = 0;
        while (cyc < 50 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt !== 2'b00) begin
                vectors++;
                if (bus.gnt !== 2'b10) begin
                    miscompares++;
                    $display("FAIL zero_len_gnt: %b, required 10", bus.gnt);
                end
                g_cyc      = cyc;
                bus.req[1] = 1'b0;
            end
            if (bus.rd_vld === 1'b1) vld_cnt++;
            if (bus.done !== 2'b00) done_cyc = cyc;
        end
        bus.req[1] = 1'b0;
        vectors++;
        if (done_cyc - g_cyc != 1 || vld_cnt != 0) begin
            miscompares++;
            $display("FAIL zero_len_timing: done after %0d beats %0d, required 1 0", done_cyc - g_cyc, vld_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int          exp_order[4] = '{0, 1, 0, 1};
        int          cyc, n_gnt, n_done, last_done, gid;
        logic [10:0] base, ea;
        @(negedge clk);
        bus.req_addr = {11'h200, 11'h100};
        bus.req_len  = {12'd2, 12'd2};
        bus.req      = 2'b11;
        cyc = 0; n_gnt = 0; n_done = 0; last_done = 0; gid = -1;
        while (cyc < 200 && n_done < 4) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt !== 2'b00) begin
                vectors++;
                if (n_gnt > 3 || bus.gnt !== 2'(1 << exp_order[n_gnt & 3])) begin
                    miscompares++;
                    $display("FAIL contention_order: grant %0d is %b, required %b", n_gnt, bus.gnt, 2'(1 << exp_order[n_gnt & 3]));
                end
                gid = (bus.gnt === 2'b01) ? 0 : (bus.gnt === 2'b10) ? 1 : -1;
                if (gid >= 0) begin
                    base = (gid == 0) ? 11'h100 : 11'h200;
                    for (int i = 0; i < 2; i++) begin
                        ea = base + 11'(i);
                        exp_q.push_back('{id: gid, data: ea[7:0], last: (i == 1), zl: 1'b0});
                    end
                end
                if (n_gnt > 0) begin
                    vectors++;
                    if (cyc - last_done < 2) begin
                        miscompares++;
                        $display("FAIL contention_gap: gnt %0d cycles after done, required >= 2", cyc - last_done);
                    end
                end
                n_gnt++;
                if (n_gnt == 4) bus.req = 2'b00;
            end
            if (bus.done !== 2'b00) begin
                vectors++;
                if (gid < 0 || bus.done !== 2'(1 << gid)) begin
                    miscompares++;
                    $display("FAIL contention_done_id: %b, required %b", bus.done, 2'(1 << gid));
                end
                n_done++;
                last_done = cyc;
            end
        end
        bus.req = 2'b00;
        vectors++;
        if (n_done != 4 || n_gnt != 4) begin
            miscompares++;
            $display("FAIL contention_count: gnts %0d dones %0d, required 4 4", n_gnt, n_done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int          cyc, beats;
        logic [10:0] ea;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            ea = 11'h300 + 11'(i);
            exp_q.push_back('{id: 0, data: ea[7:0], last: (i == 99), zl: 1'b0});
        end
        bus.req_addr[0 +: 11] = 11'h300;
        bus.req_len[0 +: 12]  = 12'd100;
        bus.req[0]            = 1'b1;
        cyc = 0; beats = 0;
        while (cyc < 300 && beats < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt !== 2'b00) bus.req[0] = 1'b0;
            if (bus.rd_vld === 1'b1) beats++;
        end
        bus.req[0] = 1'b0;
        vectors++;
        if (beats != 10) begin
            miscompares++;
            $display("FAIL midreset_beats: %0d, required 10", beats);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++;
        if (bus.rd_vld !== 1'b0 || bus.done !== 2'b00 || bus.busy !== 1'b0 || rom_addr !== 11'h000 || rom_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_clear: vld %b done %b busy %b addr %h rst %b, required 0 00 0 000 1",
                     bus.rd_vld, bus.done, bus.busy, rom_addr, rom_rst);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.done !== 2'b00 || bus.rd_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_hold: done %b vld %b, required 00 0", bus.done, bus.rd_vld);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.done !== 2'b00 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_done: done %b busy %b, required 00 0", bus.done, bus.busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_burst("single", 0, 11'h010, 4);
        test_burst("wrap", 0, 11'h7FE, 4);
        test_zero_length();
        test_contention();
        test_reset_mid_burst();
        test_burst("post_reset", 1, 11'h020, 3);
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d beats pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
